fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Single-outstanding issue controller that drives the request side of an FPU functional unit's valid/ready handshake and collects its result. It sits between the core's FPU request port and a sequential FPU unit such as the comparator. It latches an operation, presents it to the unit, waits for the result, and returns it with a tag. It also maintains the sticky NV exception flag and a watchdog for ops no unit accepts.

## Interface
- TIMEOUT, 16, cycles in ISSUE without unit acceptance before an error response; ≥1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_op  in  5  FPU op code (FPU_pkg encoding)
- req_a, req_b  in  32  operands
- req_tag  in  5  destination tag, returned unchanged
- unit_valid  out  1  to unit valid_in
- unit_ready  in  1  from unit ready_out
- unit_op  out  5  to unit op
- unit_a, unit_b  out  32  to unit a/b
- unit_res_valid  in  1  from unit valid_out
- unit_res_ready  out  1  to unit ready_in
- unit_res  in  32  from unit int_out
- unit_iv  in  1  from unit IV
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_data  out  32  result
- rsp_tag  out  5  tag of the op
- rsp_nv  out  1  op raised invalid
- rsp_err  out  1  op timed out (not accepted by any unit)
- fflags  out  5  sticky {NV,DZ,OF,UF,NX}; only NV (bit 4) driven, others 0
- fflags_clr  in  1  clear sticky flags

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch op/a/b/tag into holding registers, clear timeout counter, go to ISSUE.
- ISSUE: unit_valid=1, unit_res_ready=1. unit_op/a/b always driven from the holding registers.
  - The unit's ready_out is gated by its ready_in, so unit_res_ready must be high here.
  - unit_valid && unit_ready → WAIT.
  - Otherwise counter increments. When the counter reaches TIMEOUT-1 without acceptance: load rsp_data=0, rsp_nv=0, rsp_err=1, go to RESP.
- WAIT: unit_valid=0, unit_res_ready=1, no timeout. On unit_res_valid: capture rsp_data=unit_res, rsp_nv=unit_iv, rsp_err=0, go to RESP.
- RESP: rsp_valid=1, rsp_tag=latched tag. Outputs hold stable until rsp_ready, then go to IDLE. unit_res_ready=0 and unit_valid=0.
- fflags[4] set on the WAIT capture cycle when unit_iv=1. fflags_clr clears all bits. Clear and set in the same cycle → bit 4 ends set.
- Counter width $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset (reset=0 at an edge) → state IDLE and all outputs 0 except req_ready=1 after release.
  - Zeroed outputs include unit_valid, unit_res_ready, rsp_valid, rsp_data, rsp_tag, rsp_nv, rsp_err, fflags.
  - Holding registers and counter are also 0.
- Reset mid-operation in any state aborts the op with no response and returns to IDLE.
- A unit with 1-cycle acceptance and 1-cycle result gives:
  - request accepted at edge 0;
  - unit_valid high in cycle 1, unit accepts;
  - unit_res_valid high in cycle 2, captured at edge 3;
  - rsp_valid high from cycle 3.
- Minimum request→rsp_valid latency is 3 cycles. Throughput is 1 op per 4 cycles when rsp_ready=1.
- req_ready is combinational on state only. It never depends on req_valid.
- rsp_valid is registered and never drops before rsp_ready.
- Back-to-back: req_ready reasserts the cycle after the rsp handshake, not in the same cycle.
- Timeout response appears TIMEOUT cycles after entering ISSUE.

## Test plan
- SEQ, a=b=0x3F800000, tag=7, unit_ready=1 → rsp_valid at cycle 3, rsp_data=1, rsp_tag=7, rsp_nv=0, rsp_err=0, fflags=0.
- SLT, a=0x7F800001 (sNaN), b=0x3F800000 → rsp_data=0, rsp_nv=1, fflags=0x10. Then pulse fflags_clr → fflags=0x00.
- Unsupported op (unit_ready held 0), TIMEOUT=16 → rsp_valid exactly 16 cycles after ISSUE entry, rsp_err=1, rsp_data=0, unit_valid drops.
- Hold rsp_ready=0 for 10 cycles in RESP with a new req_valid pending → rsp_* stable, req_ready=0, no new unit_valid. On rsp_ready=1, next request accepted the following cycle.
- Assert reset=0 during WAIT → next cycle all outputs 0, no response. After release, a new SEQ request completes normally.
- Same cycle: fflags_clr=1 and a WAIT capture with unit_iv=1 → fflags=0x10.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Summary  : Single-outstanding issue controller for a sequential FPU unit,
//            with sticky NV flag and an acceptance watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  // unit request side
  output logic        unit_valid,
  input  logic        unit_ready,
  output logic [4:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  // unit result side
  input  logic        unit_res_valid,
  output logic        unit_res_ready,
  input  logic [31:0] unit_res,
  input  logic        unit_iv,
  // core response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic        rsp_nv,
  output logic        rsp_err,
  // sticky exception flags {NV,DZ,OF,UF,NX}
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [4:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [4:0]    r_tag;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_nv;
  logic          r_rsp_err;
  logic          r_nv;

  logic          w_accept;
  logic          w_timeout;
  logic          w_capture;
  logic          w_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    unit_valid     = 1'b0;
    unit_res_ready = 1'b0;
    rsp_valid      = 1'b0;
    w_accept       = 1'b0;
    w_timeout      = 1'b0;
    w_capture      = 1'b0;
    w_count        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The unit only raises ready_out while its ready_in is high.
        unit_valid     = 1'b1;
        unit_res_ready = 1'b1;
        if (unit_ready) begin
          w_next = S_WAIT;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_count = 1'b1;
        end
      end
      S_WAIT: begin
        unit_res_ready = 1'b1;
        if (unit_res_valid) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_op  <= req_op;
      r_a   <= req_a;
      r_b   <= req_b;
      r_tag <= req_tag;
    end
  end

  // Watchdog counter saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_count && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_data <= '0;
      r_rsp_nv   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_data <= '0;
      r_rsp_nv   <= 1'b0;
      r_rsp_err  <= 1'b1;
    end else if (w_capture) begin
      r_rsp_data <= unit_res;
      r_rsp_nv   <= unit_iv;
      r_rsp_err  <= 1'b0;
    end
  end

  // A new NV event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_nv <= 1'b0;
    end else if (w_capture && unit_iv) begin
      r_nv <= 1'b1;
    end else if (fflags_clr) begin
      r_nv <= 1'b0;
    end
  end

  assign unit_op  = r_op;
  assign unit_a   = r_a;
  assign unit_b   = r_b;
  assign rsp_data = r_rsp_data;
  assign rsp_tag  = r_tag;
  assign rsp_nv   = r_rsp_nv;
  assign rsp_err  = r_rsp_err;
  assign fflags   = {r_nv, 4'b0000};

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_ctrl
// Summary  : Directed scoreboard bench for fpu_issue_ctrl with a comparator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [4:0] OP_SEQ = 5'h10;
  localparam logic [4:0] OP_SLT = 5'h11;
  localparam logic [4:0] OP_BAD = 5'h1F;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        nv;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        unit_valid;
  logic        unit_ready = 1'b0;
  logic [4:0]  unit_op;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_res_valid = 1'b0;
  logic        unit_res_ready;
  logic [31:0] unit_res = '0;
  logic        unit_iv = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_nv;
  logic        rsp_err;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;

  int   errors = 0;
  int   checks = 0;
  logic hold_res = 1'b0;
  rsp_t sb[$];

  fpu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_op(unit_op),
    .unit_a(unit_a), .unit_b(unit_b),
    .unit_res_valid(unit_res_valid), .unit_res_ready(unit_res_ready),
    .unit_res(unit_res), .unit_iv(unit_iv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_nv(rsp_nv), .rsp_err(rsp_err),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  // Comparator model: returns {iv, result}.
  function automatic logic [32:0] fcmp(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic nan_any, snan_any;
    nan_any  = is_nan(a) || is_nan(b);
    snan_any = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
    if (op == OP_SEQ)
      return {snan_any, 31'd0, !nan_any && (a == b || (a[30:0] == 0 && b[30:0] == 0))};
    return {nan_any, 31'd0, !nan_any && flt(a, b)};
  endfunction

  initial begin : unit_model
    logic acc, done, rst_seen, pend;
    logic [4:0] op;
    logic [31:0] a, b;
    logic [32:0] pend_res;
    pend = 1'b0;
    pend_res = '0;
    forever begin
      @(negedge clk);
      #4;
      acc = unit_valid && unit_ready;
      done = unit_res_valid && unit_res_ready;
      rst_seen = !reset;
      op = unit_op;
      a = unit_a;
      b = unit_b;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        unit_res_valid = 1'b0;
        pend = 1'b0;
      end else begin
        if (done) unit_res_valid = 1'b0;
        if (acc) begin
          pend_res = fcmp(op, a, b);
          pend = 1'b1;
        end
        if (pend && !hold_res) begin
          unit_res_valid = 1'b1;
          {unit_iv, unit_res} = pend_res;
          pend = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_ctl"}, {req_ready, unit_valid, unit_res_ready, rsp_valid, rsp_nv, rsp_err, fflags},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
    chk({name, "_dat"}, {rsp_data, rsp_tag, unit_op}, 64'd0);
    chk({name, "_opd"}, {unit_a, unit_b}, 64'd0);
  endtask

  // Presents a request, waits for acceptance, returns one cycle after accept edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input rsp_t exp, input logic push);
    int n;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_tag = tag;
    if (push) sb.push_back(exp);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", {63'd0, n < 50}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int explat);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
    if (explat >= 0) chk({name, "_lat"}, 64'(lat), 64'(explat));
  endtask

  task automatic ack_rsp(input string name);
    rsp_t exp;
    chk({name, "_sb"}, {63'd0, sb.size() != 0}, 64'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({name, "_rsp"}, {25'd0, rsp_data, rsp_tag, rsp_nv, rsp_err}, {25'd0, exp});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_after"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin : main
    logic seen;
    int n;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    // Equal compare with a cooperative unit
    unit_ready = 1'b1;
    issue(OP_SEQ, 32'h3F800000, 32'h3F800000, 5'd7, {32'd1, 5'd7, 1'b0, 1'b0}, 1'b1);
    wait_valid("seq", 3);
    ack_rsp("seq");
    chk("seq_fflags", 64'(fflags), 64'h00);

    // Signaling NaN compare raises NV
    issue(OP_SLT, 32'h7F800001, 32'h3F800000, 5'd3, {32'd0, 5'd3, 1'b1, 1'b0}, 1'b1);
    wait_valid("slt", 3);
    ack_rsp("slt");
    chk("slt_fflags", 64'(fflags), 64'h10);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clr_fflags", 64'(fflags), 64'h00);

    // No unit accepts: watchdog response
    unit_ready = 1'b0;
    issue(OP_BAD, 32'h12345678, 32'h9ABCDEF0, 5'd9, {32'd0, 5'd9, 1'b0, 1'b1}, 1'b1);
    chk("tmo_issuing", 64'(unit_valid), 64'd1);
    wait_valid("tmo", TIMEOUT + 1);
    chk("tmo_unit_valid", 64'(unit_valid), 64'd0);
    ack_rsp("tmo");
    unit_ready = 1'b1;

    // Response backpressure with a pending request
    issue(OP_SEQ, 32'h40000000, 32'h40000000, 5'd12, {32'd1, 5'd12, 1'b0, 1'b0}, 1'b1);
    wait_valid("bp", 3);
    req_valid = 1'b1;
    req_op = OP_SLT;
    req_a = 32'h3F800000;
    req_b = 32'h40000000;
    req_tag = 5'd13;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {25'd0, rsp_valid, rsp_data, rsp_tag, rsp_nv, rsp_err, req_ready, unit_valid},
          {25'd0, 1'b1, 32'd1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    ack_rsp("bp");
    sb.push_back({32'd1, 5'd13, 1'b0, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_issue", 64'(unit_valid), 64'd1);
    wait_valid("b2b", 3);
    ack_rsp("b2b");

    // Clear and NV set in the same cycle
    chk("pre_clrset_fflags", 64'(fflags), 64'h00);
    issue(OP_SLT, 32'h7F800001, 32'h00000000, 5'd21, {32'd0, 5'd21, 1'b1, 1'b0}, 1'b1);
    n = 0;
    while (!(unit_res_valid && unit_res_ready && !unit_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clrset_wait_bound", {63'd0, n < 20}, 64'd1);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clrset_fflags", 64'(fflags), 64'h10);
    wait_valid("clrset", -1);
    ack_rsp("clrset");

    // Reset while waiting for a result
    hold_res = 1'b1;
    issue(OP_SEQ, 32'h3F800000, 32'h3F800000, 5'd5, '0, 1'b0);
    @(negedge clk);
    chk("in_wait", {62'd0, unit_valid, unit_res_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    reset = 1'b1;
    hold_res = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("no_rsp_after_reset", {63'd0, seen}, 64'd0);
    issue(OP_SEQ, 32'hC0490FDB, 32'hC0490FDB, 5'd6, {32'd1, 5'd6, 1'b0, 1'b0}, 1'b1);
    wait_valid("post", 3);
    ack_rsp("post");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
